// File: rtl/freq_gate_pkg.sv
// Shared types and constants for the gated frequency counter.
package freq_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Gate length multipliers applied to the base gate length.
    localparam int unsigned GATE_MULT [4] = '{1, 10, 100, 1000};

    function automatic int unsigned gate_mult(input logic [1:0] sel);
        return GATE_MULT[sel];
    endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Two-flop synchronizer plus history flop; flags a 0->1 transition of sig_in.
module freq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise_c
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise_c = sync2 & ~hist;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts sig_in rising edges over a selectable gate.
// FREQ_GATE_SAT_EN: saturate the edge counter and report it on overflow; else wrap.
module freq_gate_counter
    import freq_gate_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned TMR_W     = 24,
    parameter int unsigned GATE_BASE = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        sel_q;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sat;
    logic              sat_nxt;
    logic              rise_c;

    function automatic logic [TMR_W-1:0] gate_len_m1(input logic [1:0] sel);
        return TMR_W'(GATE_BASE * gate_mult(sel) - 1);
    endfunction

    freq_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise_c (rise_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_GATE;
            ST_GATE:  if (timer == '0) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = cont ? ST_GATE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next edge count including an edge seen in the current cycle.
    always_comb begin
        cnt_nxt = edge_cnt + CNT_W'(rise_c);
        sat_nxt = 1'b0;
`ifdef FREQ_GATE_SAT_EN
        sat_nxt = sat;
        if (rise_c && (edge_cnt == '1)) begin
            cnt_nxt = edge_cnt;
            sat_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= 2'd0;
            timer       <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            busy        <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q    <= gate_sel;
                        timer    <= gate_len_m1(gate_sel);
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                ST_GATE: begin
                    edge_cnt <= cnt_nxt;
                    sat      <= sat_nxt;
                    if (timer == '0) begin
                        count       <= cnt_nxt;
                        overflow    <= sat_nxt;
                        count_valid <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (cont) begin
                        timer    <= gate_len_m1(sel_q);
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter with a small gate base.
module tb_freq_gate_counter;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TMR_W     = 16;
    localparam int unsigned GATE_BASE = 4;

    typedef struct {
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic [1:0]       gate_sel = 2'd0;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   sig_period = 0;
    logic sig_level  = 1'b0;
    int   sig_ph     = 0;
    int   mult_tb [4] = '{1, 10, 100, 1000};
    exp_t sb [$];

    freq_gate_counter #(
        .CNT_W     (CNT_W),
        .TMR_W     (TMR_W),
        .GATE_BASE (GATE_BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .start       (start),
        .cont        (cont),
        .gate_sel    (gate_sel),
        .count       (count),
        .count_valid (count_valid),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Square wave of sig_period clocks, or a static level when sig_period is 0.
    always @(negedge clk) begin
        if (sig_period == 0) begin
            sig_in = sig_level;
            sig_ph = 0;
        end else begin
            sig_ph = sig_ph + 1;
            if (sig_ph >= sig_period / 2) begin
                sig_ph = 0;
                sig_in = ~sig_in;
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (count_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("count", count, e.cnt);
                check("overflow", overflow, e.ovf);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [1:0] sel, input int exp_cnt, input int exp_ovf,
                               input int n_results);
        int n;
        exp_t e;
        n = int'(GATE_BASE) * mult_tb[sel];
        for (int k = 0; k < n_results; k++) begin
            e.cnt = exp_cnt;
            e.ovf = exp_ovf;
            e.cyc = cyc + 1 + n + k * (n + 1);
            sb.push_back(e);
        end
        gate_sel = sel;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int busy_n;

        tick(3);
        check("rst_count", count, 0);
        check("rst_valid", count_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // Single gate of 40 cycles at period 4: 10 edges, busy for 41 cycles.
        sig_period = 4;
        tick(8);
        pulse_start(2'd1, 10, 0, 1);
        busy_n = busy ? 1 : 0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (busy) busy_n++;
            else break;
        end
        check("busy_cycles", busy_n, 41);
        wait_drain(20);

        // Static high input: no edges within the gate.
        sig_period = 0;
        sig_level  = 1'b1;
        tick(6);
        pulse_start(2'd0, 0, 0, 1);
        wait_drain(20);
        tick(2);

        // Longest gate at period 2: 2000 edges exceed the 8-bit counter.
        sig_period = 2;
        tick(6);
`ifdef FREQ_GATE_SAT_EN
        pulse_start(2'd3, 255, 1, 1);
`else
        pulse_start(2'd3, 208, 0, 1);
`endif
        wait_drain(4100);
        tick(2);

        // Continuous mode: back-to-back results, then stop after the third.
        sig_period = 4;
        tick(8);
        cont = 1'b1;
        pulse_start(2'd1, 10, 0, 3);
        for (int k = 0; k < 200 && sb.size() > 1; k++) tick(1);
        tick(5);
        cont = 1'b0;
        wait_drain(100);
        tick(2);
        check("cont_stop_busy", busy, 0);
        check("cont_stop_overflow", overflow, 0);

        // Reset mid-gate discards the measurement and clears outputs at once.
        pulse_start(2'd1, 0, 0, 0);
        tick(15);
        rst = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_valid", count_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        tick(2);
        rst = 1'b0;
        tick(60);
        check("midrst_idle_busy", busy, 0);
        pulse_start(2'd1, 10, 0, 1);
        wait_drain(100);
        tick(2);

        // start and gate_sel changes during a gate are ignored.
        pulse_start(2'd0, 1, 0, 1);
        start    = 1'b1;
        gate_sel = 2'd3;
        tick(1);
        start    = 1'b0;
        wait_drain(30);
        tick(3);
        check("ignore_busy", busy, 0);
        gate_sel = 2'd0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 Parameter CNT_W, default 24: width of edge counter and count output.
REQ-002 Parameter TMR_W, default 24: width of gate timer; SHALL hold 1000*GATE_BASE.
REQ-003 Parameter GATE_BASE, default 10000: shortest gate length in clk cycles.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 sig_in  in  1  measured signal, asynchronous to clk.
REQ-007 start  in  1  level-sampled request to begin a measurement.
REQ-008 cont  in  1  1 = re-arm automatically after each result.
REQ-009 gate_sel  in  2  gate length select: N = GATE_BASE * {1,10,100,1000}[gate_sel].
REQ-010 count  out  CNT_W  rising edges counted in last completed gate.
REQ-011 count_valid  out  1  one-cycle pulse: count/overflow updated.
REQ-012 overflow  out  1  edge counter saturated during last gate.
REQ-013 busy  out  1  measurement in progress.

Function
REQ-014 sig_in SHALL pass a 2-flop synchronizer plus one history flop; rising edge = sync 0->1; detection latency 2-3 clk.
REQ-015 FSM states SHALL be IDLE, GATE, LATCH.
REQ-016 IDLE: start=1 sampled -> GATE; same edge clears edge counter, clears saturation flag, loads timer with N-1, captures gate_sel.
REQ-017 GATE SHALL last exactly N cycles; each detected edge in those cycles, including the last, increments the edge counter.
REQ-018 Timer=0 in GATE -> LATCH; same edge registers count, overflow and sets count_valid.
REQ-019 count_valid SHALL be high exactly during the single LATCH cycle, i.e. N+1 edges after the edge sampling start.
REQ-020 LATCH -> GATE (counter cleared, timer reloaded from held gate_sel) if cont=1, else -> IDLE; edges in the LATCH cycle are not counted.
REQ-021 start in GATE or LATCH SHALL be ignored; gate_sel changes after capture SHALL have no effect until the next IDLE->GATE.
REQ-022 busy SHALL be 1 in GATE and LATCH, 0 in IDLE.
REQ-023 count and overflow SHALL hold their value until the next LATCH.

Reset
REQ-024 rst SHALL immediately force IDLE and clear synchronizer, history flop, timer, edge counter, count, count_valid, overflow, busy to 0, including mid-GATE; in-flight result discarded.

Configuration
REQ-025 FREQ_GATE_SAT_EN defined: edge counter SHALL stop at 2^CNT_W-1 and set the saturation flag, reported on overflow at LATCH.
REQ-026 FREQ_GATE_SAT_EN undefined: edge counter SHALL wrap modulo 2^CNT_W; overflow SHALL be constant 0.

Structure
REQ-027 Package freq_gate_pkg SHALL hold the FSM state enum and the gate multiplier table {1,10,100,1000}.
REQ-028 The synchronizer + edge detect SHALL be sub-module freq_edge_sync (clk, rst, sig_in -> rise pulse).

Verification (GATE_BASE=4, CNT_W=8, TMR_W=16)
REQ-029 sig_in period 4 clk, gate_sel=1, start pulse -> one count_valid, count=10, overflow=0, busy high 41 cycles.
REQ-030 sig_in held 1, gate_sel=0, start pulse -> count_valid 5 edges after start sampled, count=0.
REQ-031 sig_in period 2 clk, gate_sel=3 -> with FREQ_GATE_SAT_EN count=255, overflow=1; without, count=208, overflow=0.
REQ-032 cont=1, gate_sel=1, sig_in period 4 -> count_valid pulses every 41 cycles, each count=10; cont=0 -> IDLE after current LATCH.
REQ-033 rst pulse mid-GATE -> all outputs 0 in same cycle, no count_valid; subsequent start yields correct fresh count.
REQ-034 start re-asserted and gate_sel changed 0->3 during GATE -> ignored; gate length and result follow original gate_sel.
